two_to_four_hold_decoder: RTL

Registered 2-to-4 decoder forming the receive side of the 4-to-2 priority encoder path: it accepts an encoded index ({y1,y2} plus an any-active flag) under a valid/ready handshake and drives the matching one-hot line. Each decoded code is held for a programmable number of cycles, then released. Sits downstream of the priority encoder, regenerating one-hot select/grant lines for the consuming logic.

---
 rtl/two_to_four_hold_decoder.sv | 108 ++++++++++
 1 files changed

// File: rtl/two_to_four_hold_decoder.sv
// Registered 2-to-4 decoder with valid/ready intake: each accepted code is
// driven one-hot on out for HOLD_CYCLES cycles, back-to-back when refilled.
module two_to_four_hold_decoder #(
    parameter int HOLD_CYCLES = 4,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             y1,
    input  logic             y2,
    input  logic             in_any,
    output logic [3:0]       out,
    output logic             out_valid,
    output logic             busy,
    output logic [CNT_W-1:0] accept_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(HOLD_CYCLES - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] hold_cnt, hold_cnt_nxt;
    logic [3:0]       out_nxt;
    logic             out_valid_nxt;
    logic [CNT_W-1:0] accept_cnt_nxt;
    logic             hold_last;
    logic             accept;

    // A no-request code decodes to all-zero but is still a valid output.
    function automatic logic [3:0] decode(input logic any, input logic [1:0] code);
        if (!any) begin
            return 4'b0000;
        end
        return 4'b0001 << code;
    endfunction

    assign hold_last = (hold_cnt == LAST_CNT);
    assign in_ready  = (state == IDLE) || hold_last;
    assign accept    = in_valid && in_ready;
    assign busy      = (state == HOLD);

    always_comb begin
        state_nxt      = state;
        hold_cnt_nxt   = hold_cnt;
        out_nxt        = out;
        out_valid_nxt  = out_valid;
        accept_cnt_nxt = accept_cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt      = HOLD;
                    hold_cnt_nxt   = '0;
                    out_nxt        = decode(in_any, {y1, y2});
                    out_valid_nxt  = 1'b1;
                    accept_cnt_nxt = accept_cnt + CNT_W'(1);
                end else begin
                    out_nxt       = 4'b0000;
                    out_valid_nxt = 1'b0;
                end
            end
            HOLD: begin
                if (!hold_last) begin
                    hold_cnt_nxt = hold_cnt + CNT_W'(1);
                end else if (accept) begin
                    // Refill on the final hold cycle so out_valid never drops.
                    hold_cnt_nxt   = '0;
                    out_nxt        = decode(in_any, {y1, y2});
                    out_valid_nxt  = 1'b1;
                    accept_cnt_nxt = accept_cnt + CNT_W'(1);
                end else begin
                    state_nxt     = IDLE;
                    hold_cnt_nxt  = '0;
                    out_nxt       = 4'b0000;
                    out_valid_nxt = 1'b0;
                end
            end
            default: begin
                state_nxt     = IDLE;
                hold_cnt_nxt  = '0;
                out_nxt       = 4'b0000;
                out_valid_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            hold_cnt   <= '0;
            out        <= 4'b0000;
            out_valid  <= 1'b0;
            accept_cnt <= '0;
        end else begin
            state      <= state_nxt;
            hold_cnt   <= hold_cnt_nxt;
            out        <= out_nxt;
            out_valid  <= out_valid_nxt;
            accept_cnt <= accept_cnt_nxt;
        end
    end

endmodule
